// File: rtl/sti_deserializer.sv
// Serial-to-parallel frame receiver: 8/16/24/32-bit frames, MSB- or LSB-first,
// with a 16-bit payload window and error strobes for bad padding or truncated frames.
module sti_deserializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_load,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_fill,
    input  logic        cfg_msb,
    input  logic        cfg_low,
    input  logic        si_data,
    input  logic        si_valid,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        po_err,
    output logic        po_busy,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, RECV} state_t;

    state_t      state, state_nxt;
    logic [1:0]  len_q, len_nxt;
    logic        fill_q, fill_nxt;
    logic        msb_q, msb_nxt;
    logic        low_q, low_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [31:0] frame, frame_nxt, frame_smp;
    logic [15:0] data_nxt, payload;
    logic        valid_nxt, err_nxt, pad_err;
    logic [7:0]  fcnt_nxt;
    logic [4:0]  last, idx;

    // {len,3'b111} is N-1 for N = 8,16,24,32
    assign last    = {len_q, 3'b111};
    assign idx     = msb_q ? (last - cnt) : cnt;
    assign po_busy = (state != IDLE);

    // Frame with the current bit written in; a new frame starts from zero in ARMED.
    always_comb begin
        frame_smp      = (state == ARMED) ? 32'h0 : frame;
        frame_smp[idx] = si_data;
    end

    always_comb begin
        payload = frame_smp[15:0];
        pad_err = 1'b0;
        case (len_q)
            2'd0: payload = low_q ? {8'h00, frame_smp[7:0]} : {frame_smp[7:0], 8'h00};
            2'd1: payload = frame_smp[15:0];
            2'd2: begin
                if (fill_q) begin
                    payload = frame_smp[23:8];
                    pad_err = |frame_smp[7:0];
                end else begin
                    payload = frame_smp[15:0];
                    pad_err = |frame_smp[23:16];
                end
            end
            default: begin
                if (fill_q) begin
                    payload = frame_smp[31:16];
                    pad_err = |frame_smp[15:0];
                end else begin
                    payload = frame_smp[15:0];
                    pad_err = |frame_smp[31:16];
                end
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        fill_nxt  = fill_q;
        msb_nxt   = msb_q;
        low_nxt   = low_q;
        cnt_nxt   = cnt;
        frame_nxt = frame;
        data_nxt  = po_data;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        fcnt_nxt  = frame_cnt;
        case (state)
            IDLE: begin
                if (cfg_load) begin
                    len_nxt   = cfg_length;
                    fill_nxt  = cfg_fill;
                    msb_nxt   = cfg_msb;
                    low_nxt   = cfg_low;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (si_valid) begin
                    frame_nxt = frame_smp;
                    cnt_nxt   = 5'd1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (si_valid) begin
                    frame_nxt = frame_smp;
                    if (cnt == last) begin
                        data_nxt  = payload;
                        valid_nxt = 1'b1;
                        err_nxt   = pad_err;
                        fcnt_nxt  = frame_cnt + 8'd1;
                        cnt_nxt   = 5'd0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end else begin
                    // truncated frame: drop it and flag
                    err_nxt   = 1'b1;
                    cnt_nxt   = 5'd0;
                    frame_nxt = 32'h0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= 2'd0;
            fill_q    <= 1'b0;
            msb_q     <= 1'b0;
            low_q     <= 1'b0;
            cnt       <= 5'd0;
            frame     <= 32'h0;
            po_data   <= 16'h0000;
            po_valid  <= 1'b0;
            po_err    <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            fill_q    <= fill_nxt;
            msb_q     <= msb_nxt;
            low_q     <= low_nxt;
            cnt       <= cnt_nxt;
            frame     <= frame_nxt;
            po_data   <= data_nxt;
            po_valid  <= valid_nxt;
            po_err    <= err_nxt;
            frame_cnt <= fcnt_nxt;
        end
    end

endmodule

// File: tb/tb_sti_deserializer.sv
// Scoreboard bench for sti_deserializer: directed frames push expected strobes,
// a negedge monitor pops and compares whenever po_valid or po_err fires.
module tb_sti_deserializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  cfg_length = 2'd0;
    logic        cfg_fill = 1'b0;
    logic        cfg_msb = 1'b0;
    logic        cfg_low = 1'b0;
    logic        si_data = 1'b0;
    logic        si_valid = 1'b0;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_err;
    logic        po_busy;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    sti_deserializer dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_length (cfg_length),
        .cfg_fill   (cfg_fill),
        .cfg_msb    (cfg_msb),
        .cfg_low    (cfg_low),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_err     (po_err),
        .po_busy    (po_busy),
        .frame_cnt  (frame_cnt)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        err;
        logic        valid;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [15:0] last_data = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && (po_valid || po_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual valid=%0b err=%0b data=%0h expected none",
                         po_valid, po_err, po_data);
            end else begin
                e = q.pop_front();
                check("sb_valid", {31'h0, po_valid}, {31'h0, e.valid});
                check("sb_err", {31'h0, po_err}, {31'h0, e.err});
                check("sb_data", {16'h0, po_data}, {16'h0, e.data});
                if (po_valid) check("sb_busy_in_valid", {31'h0, po_busy}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [1:0] len, input logic fill, input logic msb,
                            input logic low, input logic sv);
        cfg_length = len;
        cfg_fill   = fill;
        cfg_msb    = msb;
        cfg_low    = low;
        cfg_load   = 1'b1;
        si_valid   = sv;
        si_data    = sv;
        tick();
        cfg_load   = 1'b0;
        si_valid   = 1'b0;
        si_data    = 1'b0;
    endtask

    // send the first k bits of an n-bit frame f, then drop si_valid
    task automatic send_bits(input logic [31:0] f, input int n, input int k, input logic msb);
        for (int i = 0; i < k; i++) begin
            si_valid = 1'b1;
            si_data  = msb ? f[n-1-i] : f[i];
            tick();
        end
        si_valid = 1'b0;
        si_data  = 1'b0;
    endtask

    task automatic expect_frame(input logic [15:0] data, input logic err);
        q.push_back({data, err, 1'b1});
        last_data = data;
        exp_cnt   = (exp_cnt + 1) % 256;
    endtask

    initial begin
        logic [7:0] b;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", {16'h0, po_data}, 32'h0);
        check("rst_valid", {31'h0, po_valid}, 32'h0);
        check("rst_err", {31'h0, po_err}, 32'h0);
        check("rst_busy", {31'h0, po_busy}, 32'h0);
        check("rst_cnt", {24'h0, frame_cnt}, 32'h0);
        reset = 1'b1;
        tick();

        // 16-bit MSB-first
        load_cfg(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("armed_busy", {31'h0, po_busy}, 32'h1);
        expect_frame(16'hA5C3, 1'b0);
        send_bits(32'hA5C3, 16, 16, 1'b1);
        check("s1_latency_valid", {31'h0, po_valid}, 32'h1);
        check("s1_data", {16'h0, po_data}, 32'hA5C3);
        tick();
        check("s1_valid_one_cycle", {31'h0, po_valid}, 32'h0);
        check("s1_data_hold", {16'h0, po_data}, 32'hA5C3);
        check("s1_cnt", {24'h0, frame_cnt}, exp_cnt);

        // 8-bit LSB-first; first load coincides with si_valid and ARMED waits
        load_cfg(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        check("armed_wait_busy", {31'h0, po_busy}, 32'h1);
        expect_frame(16'h003C, 1'b0);
        send_bits(32'h3C, 8, 8, 1'b0);
        load_cfg(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_frame(16'h3C00, 1'b0);
        send_bits(32'h3C, 8, 8, 1'b0);
        tick();
        check("s2_cnt", {24'h0, frame_cnt}, exp_cnt);

        // 32/24-bit payload windows and padding errors
        load_cfg(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_frame(16'h1234, 1'b0);
        send_bits(32'h12340000, 32, 32, 1'b1);
        load_cfg(2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_frame(16'hABCD, 1'b0);
        send_bits(32'h0000ABCD, 32, 32, 1'b1);
        load_cfg(2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_frame(16'hABCD, 1'b1);
        send_bits(32'h8000ABCD, 32, 32, 1'b1);
        load_cfg(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_frame(16'hBEEF, 1'b0);
        send_bits(32'hBEEF00, 24, 24, 1'b1);
        load_cfg(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_frame(16'hABCD, 1'b1);
        send_bits(32'h01ABCD, 24, 24, 1'b0);
        tick();
        check("s3_cnt", {24'h0, frame_cnt}, exp_cnt);

        // truncated 24-bit frame
        load_cfg(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        q.push_back({last_data, 1'b1, 1'b0});
        send_bits(32'hFFFFFF, 24, 10, 1'b1);
        tick();
        check("s4_err", {31'h0, po_err}, 32'h1);
        check("s4_no_valid", {31'h0, po_valid}, 32'h0);
        check("s4_busy", {31'h0, po_busy}, 32'h0);
        check("s4_cnt", {24'h0, frame_cnt}, exp_cnt);
        tick();
        check("s4_err_one_cycle", {31'h0, po_err}, 32'h0);

        // reset mid-frame
        load_cfg(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(32'hFFFF, 16, 5, 1'b1);
        reset = 1'b0;
        #1;
        check("s5_rst_data", {16'h0, po_data}, 32'h0);
        check("s5_rst_busy", {31'h0, po_busy}, 32'h0);
        check("s5_rst_cnt", {24'h0, frame_cnt}, 32'h0);
        exp_cnt   = 0;
        last_data = 16'h0;
        tick();
        reset = 1'b1;
        tick();
        check("s5_post_busy", {31'h0, po_busy}, 32'h0);
        load_cfg(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_frame(16'h0F0F, 1'b0);
        send_bits(32'h0F0F, 16, 16, 1'b1);
        tick();
        check("s5_cnt", {24'h0, frame_cnt}, exp_cnt);

        // 256 back-to-back byte frames, cfg_load in each po_valid cycle
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_cnt = 0;
        tick();
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            load_cfg(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            expect_frame({8'h00, b}, 1'b0);
            send_bits({24'h0, b}, 8, 8, 1'b1);
            if (i == 254) check("s6_cnt_255", {24'h0, frame_cnt}, 32'd255);
        end
        tick();
        check("s6_cnt_wrap", {24'h0, frame_cnt}, 32'd0);
        check("s6_cnt_model", {24'h0, frame_cnt}, exp_cnt);

        repeat (3) tick();
        check("sb_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sti_deserializer.md
STI_DESERIALIZER -- requirements
Module: sti_deserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cfg_load  in  1  latch frame configuration (IDLE only)
- cfg_length  in  2  frame length: 00=8, 01=16, 10=24, 11=32 bits
- cfg_fill  in  1  for 24/32-bit frames: 1 = payload in upper 16 bits, 0 = payload in lower 16 bits
- cfg_msb  in  1  1 = first received bit is frame MSB, 0 = frame LSB
- cfg_low  in  1  8-bit frames: 1 = byte goes to po_data[7:0], 0 = po_data[15:8]
- si_data  in  1  serial data bit
- si_valid  in  1  serial bit qualifier, high for the whole frame
- po_data  out  16  reconstructed parallel word
- po_valid  out  1  one-cycle result strobe
- po_err  out  1  one-cycle error strobe
- po_busy  out  1  high when state is not IDLE
- frame_cnt  out  8  count of completed frames, wraps

Function
REQ-003 The state machine SHALL have three states: IDLE, ARMED and RECV.
REQ-004 In IDLE, cfg_load=1 SHALL latch all cfg_* inputs and move to ARMED; si_valid in IDLE SHALL be ignored.
REQ-005 If cfg_load and si_valid are both high in IDLE in the same cycle, the block SHALL latch the configuration only and SHALL NOT sample that bit.
REQ-006 In ARMED, the first edge with si_valid=1 SHALL sample bit 0 and move to RECV; the block SHALL remain in ARMED indefinitely while si_valid=0.
REQ-007 In RECV, one bit SHALL be sampled on each edge with si_valid=1, using a bit counter of 0..N-1.
REQ-008 cfg_load SHALL be ignored in ARMED and RECV.
REQ-009 Bits SHALL be assembled into an N-bit frame F: with cfg_msb=1 the first bit is F[N-1], descending; with cfg_msb=0 the first bit is F[0], ascending.
REQ-010 Payload extraction SHALL be:
- N=8: po_data = cfg_low ? {8'h00,F[7:0]} : {F[7:0],8'h00}
- N=16: po_data = F
- N=24/32 with cfg_fill=1: po_data = F[N-1:N-16]
- N=24/32 with cfg_fill=0: po_data = F[15:0]
REQ-011 On the edge that samples bit N-1, the block SHALL register po_data and set po_valid=1 for exactly the following cycle (latency: 1 cycle after the last bit), increment frame_cnt, and return to IDLE.
REQ-012 For 24/32-bit frames, any non-zero padding bit SHALL assert po_err in the same cycle as po_valid; the data is still delivered.
REQ-013 If si_valid falls in RECV before bit N-1 is sampled, the block SHALL pulse po_err for 1 cycle with po_valid=0, discard the partial frame, leave frame_cnt unchanged and return to IDLE.
REQ-014 po_data SHALL hold its last value until the next po_valid.
REQ-015 frame_cnt SHALL wrap from 255 to 0.
REQ-016 po_busy SHALL be 0 in the po_valid cycle, so a cfg_load in that cycle SHALL be accepted.

Reset
REQ-017 While reset=0, the block SHALL be in IDLE with po_data=16'h0000, po_valid=0, po_err=0, po_busy=0, frame_cnt=0, the bit counter cleared and the configuration cleared.
REQ-018 Reset asserted mid-frame SHALL abort the frame with no po_valid or po_err pulse.

Verification
REQ-019 The bench SHALL cover these scenarios:
- len=16, msb=1, serial 0xA5C3 -> po_data=0xA5C3, po_valid one cycle after the 16th bit, frame_cnt=1.
- len=8, msb=0, low=1, byte 0x3C LSB-first -> 0x003C; repeat with low=0 -> 0x3C00.
- len=32, msb=1, fill=1, frame 0x12340000 -> 0x1234, po_err=0; fill=0, frame 0x0000ABCD -> 0xABCD; fill=0, frame 0x8000ABCD -> 0xABCD with po_err=1.
- len=24, si_valid dropped after 10 bits -> po_err pulse, no po_valid, frame_cnt unchanged, po_busy=0 next cycle.
- reset pulsed low after 5 bits of a 16-bit frame -> all outputs zero immediately; next frame 0x0F0F decodes correctly.
- 256 back-to-back 8-bit frames with cfg_load issued in each po_valid cycle -> no frame lost, frame_cnt returns to 0.
